zero_branch_unit: RTL and testbench

Program-counter and conditional-branch sequencer for one core; it reads the zero flag produced by `isZeroReg`. Each enabled cycle it chooses the next PC: increment, unconditional jump, jump-if-zero or jump-if-not-zero. If the flag is being rewritten in the same cycle as a conditional branch, the unit stalls one cycle and resolves the branch against the updated flag. One instance sits between each core's decode stage and its instruction-memory address port.

---
 rtl/branch_pkg.sv | 17 +
 rtl/branch_cond.sv | 20 ++
 rtl/zero_branch_unit.sv | 108 ++++++++++
 tb/tb_zero_branch_unit.sv | 126 ++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared encodings for the zero-flag branch sequencer: branch opcodes and FSM states.
package branch_pkg;

  typedef enum logic [1:0] {
    BR_NONE  = 2'b00,
    BR_JMP   = 2'b01,
    BR_JMPZ  = 2'b10,
    BR_JMPNZ = 2'b11
  } br_op_e;

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_RESOLVE = 2'b01,
    ST_HALT    = 2'b10
  } br_state_e;

endpackage

// File: rtl/branch_cond.sv
// Combinational branch decision: is this op taken given the zero flag.
module branch_cond
  import branch_pkg::*;
(
  input  br_op_e op_i,
  input  logic   zero_i,
  output logic   taken_o
);

  always_comb begin
    taken_o = 1'b0;
    case (op_i)
      BR_JMP:   taken_o = 1'b1;
      BR_JMPZ:  taken_o = zero_i;
      BR_JMPNZ: taken_o = ~zero_i;
      default:  taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/zero_branch_unit.sv
// PC sequencer with conditional branches on the isZeroReg flag; stalls one cycle
// when a conditional branch coincides with a flag write.
module zero_branch_unit
  import branch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  pcEn,
  input  logic [1:0]            brOp,
  input  logic [ADDR_WIDTH-1:0] brTarget,
  input  logic                  zeroFlag,
  input  logic                  zeroWriteEn,
  input  logic                  haltIn,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  branchTaken,
  output logic                  stall,
  output logic                  halted,
  output logic [CNT_WIDTH-1:0]  takenCount
);

  br_state_e             state_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic                  taken_q;
  br_op_e                op_q;
  logic [ADDR_WIDTH-1:0] tgt_q;
  logic [CNT_WIDTH-1:0]  cnt_q;

  br_op_e                op_in;
  br_op_e                cond_op;
  logic                  cond_taken;
  logic [ADDR_WIDTH-1:0] tgt_sel;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign op_in = br_op_e'(brOp);

  // RESOLVE re-evaluates the latched op; RUN evaluates the live op.
  always_comb begin
    cond_op = op_in;
    tgt_sel = brTarget;
    if (state_q == ST_RESOLVE) begin
      cond_op = op_q;
      tgt_sel = tgt_q;
    end
  end

  branch_cond u_cond (
    .op_i    (cond_op),
    .zero_i  (zeroFlag),
    .taken_o (cond_taken)
  );

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      taken_q <= 1'b0;
      op_q    <= BR_NONE;
      tgt_q   <= '0;
      cnt_q   <= '0;
    end else if (!pcEn) begin
      taken_q <= 1'b0;
    end else begin
      taken_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (haltIn) begin
            state_q <= ST_HALT;
          end else if ((op_in == BR_JMPZ || op_in == BR_JMPNZ) && zeroWriteEn) begin
            op_q    <= op_in;
            tgt_q   <= brTarget;
            state_q <= ST_RESOLVE;
          end else if (cond_taken) begin
            pc_q    <= tgt_sel;
            taken_q <= 1'b1;
            cnt_q   <= sat_inc(cnt_q);
          end else begin
            pc_q <= pc_q + 1'b1;
          end
        end
        ST_RESOLVE: begin
          state_q <= ST_RUN;
          if (cond_taken) begin
            pc_q    <= tgt_sel;
            taken_q <= 1'b1;
            cnt_q   <= sat_inc(cnt_q);
          end else begin
            pc_q <= pc_q + 1'b1;
          end
        end
        default: state_q <= ST_HALT;
      endcase
    end
  end

  assign pc          = pc_q;
  assign branchTaken = taken_q;
  assign stall       = (state_q == ST_RESOLVE);
  assign halted      = (state_q == ST_HALT);
  assign takenCount  = cnt_q;

endmodule

// File: tb/tb_zero_branch_unit.sv
// Directed bench for zero_branch_unit (RESET_PC=0x10, CNT_WIDTH=2).
module tb_zero_branch_unit;

  logic       clock = 1'b0;
  logic       rst, pcEn, zeroFlag, zeroWriteEn, haltIn;
  logic [1:0] brOp;
  logic [7:0] brTarget;
  logic [7:0] pc;
  logic       branchTaken, stall, halted;
  logic [1:0] takenCount;

  int checks   = 0;
  int failures = 0;

  zero_branch_unit #(.ADDR_WIDTH(8), .RESET_PC(8'h10), .CNT_WIDTH(2)) dut (
    .clock       (clock),
    .rst         (rst),
    .pcEn        (pcEn),
    .brOp        (brOp),
    .brTarget    (brTarget),
    .zeroFlag    (zeroFlag),
    .zeroWriteEn (zeroWriteEn),
    .haltIn      (haltIn),
    .pc          (pc),
    .branchTaken (branchTaken),
    .stall       (stall),
    .halted      (halted),
    .takenCount  (takenCount)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [7:0] tgt,
                       input logic zf, input logic wen, input logic hlt);
    brOp = op; brTarget = tgt; zeroFlag = zf; zeroWriteEn = wen; haltIn = hlt;
  endtask

  task automatic expect_out(input string tag, input logic [7:0] epc, input logic etk,
                            input logic est, input logic ehl, input logic [1:0] ecnt);
    check({tag, ".pc"},    32'(pc),          32'(epc));
    check({tag, ".taken"}, 32'(branchTaken), 32'(etk));
    check({tag, ".stall"}, 32'(stall),       32'(est));
    check({tag, ".halt"},  32'(halted),      32'(ehl));
    check({tag, ".cnt"},   32'(takenCount),  32'(ecnt));
  endtask

  initial begin
    rst = 1'b1; pcEn = 1'b0;
    drive(2'b00, 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    expect_out("reset", 8'h10, 0, 0, 0, 2'd0);

    rst = 1'b0; pcEn = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      expect_out("incr", 8'(8'h10 + i), 0, 0, 0, 2'd0);
    end

    drive(2'b01, 8'hFF, 0, 0, 0); step(); expect_out("jmp_ff", 8'hFF, 1, 0, 0, 2'd1);
    drive(2'b00, 8'h00, 0, 0, 0); step(); expect_out("wrap",   8'h00, 0, 0, 0, 2'd1);
    drive(2'b01, 8'h40, 0, 0, 0); step(); expect_out("jmp_40", 8'h40, 1, 0, 0, 2'd2);
    drive(2'b10, 8'h80, 0, 0, 0); step(); expect_out("jmpz_nt", 8'h41, 0, 0, 0, 2'd2);
    drive(2'b10, 8'h50, 1, 0, 0); step(); expect_out("jmpz_t", 8'h50, 1, 0, 0, 2'd3);
    drive(2'b00, 8'h00, 0, 1, 0); step(); expect_out("wen_none", 8'h51, 0, 0, 0, 2'd3);

    // hazard: JMPNZ while flag 1 -> 0
    rst = 1'b1; step(); rst = 1'b0;
    drive(2'b01, 8'h20, 0, 0, 0); step(); expect_out("jmp_20", 8'h20, 1, 0, 0, 2'd1);
    drive(2'b11, 8'h30, 1, 1, 0); step(); expect_out("hz1_stall", 8'h20, 0, 1, 0, 2'd1);
    drive(2'b00, 8'h00, 0, 0, 1); step(); expect_out("hz1_res", 8'h30, 1, 0, 0, 2'd2);

    // hazard: JMPNZ while flag 0 -> 1, not taken
    drive(2'b11, 8'h60, 0, 1, 0); step(); expect_out("hz2_stall", 8'h30, 0, 1, 0, 2'd2);
    drive(2'b01, 8'hAA, 1, 1, 0); step(); expect_out("hz2_res", 8'h31, 0, 0, 0, 2'd2);

    // pcEn dropped for two cycles during RESOLVE
    drive(2'b10, 8'h70, 0, 1, 0); step(); expect_out("hz3_stall", 8'h31, 0, 1, 0, 2'd2);
    pcEn = 1'b0; drive(2'b00, 8'h00, 1, 0, 0);
    step(); expect_out("hz3_hold1", 8'h31, 0, 1, 0, 2'd2);
    step(); expect_out("hz3_hold2", 8'h31, 0, 1, 0, 2'd2);
    pcEn = 1'b1; step(); expect_out("hz3_res", 8'h70, 1, 0, 0, 2'd3);

    // enable low in RUN holds everything
    pcEn = 1'b0; drive(2'b01, 8'h99, 0, 0, 0); step(); expect_out("en_low", 8'h70, 0, 0, 0, 2'd3);
    // branch to current PC, counter saturated
    pcEn = 1'b1; drive(2'b01, 8'h70, 0, 0, 0); step(); expect_out("self_jmp", 8'h70, 1, 0, 0, 2'd3);

    // reset in the middle of RESOLVE
    drive(2'b10, 8'h77, 0, 1, 0); step(); expect_out("hz4_stall", 8'h70, 0, 1, 0, 2'd3);
    rst = 1'b1; step(); expect_out("rst_resolve", 8'h10, 0, 0, 0, 2'd0);
    rst = 1'b0;

    // halt together with JMP
    drive(2'b01, 8'h55, 0, 0, 1); step(); expect_out("halt", 8'h10, 0, 0, 1, 2'd0);
    drive(2'b01, 8'h66, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(); expect_out("halt_hold", 8'h10, 0, 0, 1, 2'd0);
    end
    rst = 1'b1; step(); expect_out("halt_rst", 8'h10, 0, 0, 0, 2'd0);
    rst = 1'b0;

    // saturation over four taken branches
    for (int i = 1; i <= 4; i++) begin
      drive(2'b01, 8'(8'h80 + i), 0, 0, 0);
      step();
      expect_out("sat", 8'(8'h80 + i), 1, 0, 0, (i >= 3) ? 2'd3 : 2'(i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
